// File: rtl/sm_run_ctrl.sv
// sm_run_ctrl
//   Run-control sequencer for the single-cycle CPU. Gates the CPU clock
//   enable so the CPU can be halted, run freely, single-stepped, or run for
//   N instructions. It also halts when the PC matches an enabled breakpoint.
//   Each cycle with cpuEn high retires exactly one instruction.
//
// Ports
//   clk        : CPU clock, all state updates on posedge
//   rst        : synchronous reset, active-high
//   cmdValid   : command request
//   cmd        : 00 HALT, 01 RUN, 10 STEP, 11 RUNN
//   cmdCount   : instruction count for RUNN
//   cmdReady   : command accepted when cmdValid && cmdReady at posedge
//   bpEnable   : breakpoint enable
//   bpAddr     : breakpoint PC
//   pc         : PC of the instruction about to execute
//   cpuEn      : CPU clock enable (combinational from state/pc)
//   halted     : 1 while in HALT
//   haltCause  : 00 reset, 01 user HALT, 10 step/count done, 11 breakpoint
//   cycleCount : cpuEn cycles since reset, wraps at 2^32
module sm_run_ctrl #(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned ADDR_W       = 32,
    parameter bit          RUN_ON_RESET = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmdValid,
    input  logic [1:0]        cmd,
    input  logic [CNT_W-1:0]  cmdCount,
    output logic              cmdReady,
    input  logic              bpEnable,
    input  logic [ADDR_W-1:0] bpAddr,
    input  logic [ADDR_W-1:0] pc,
    output logic              cpuEn,
    output logic              halted,
    output logic [1:0]        haltCause,
    output logic [31:0]       cycleCount
);

    typedef enum logic [1:0] {
        S_HALT = 2'b00,
        S_RUN  = 2'b01,
        S_RUNN = 2'b10,
        S_STEP = 2'b11
    } state_e;

    localparam logic [1:0] CMD_HALT = 2'b00;
    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_RUNN = 2'b11;

    localparam logic [1:0] CAUSE_RESET = 2'b00;
    localparam logic [1:0] CAUSE_USER  = 2'b01;
    localparam logic [1:0] CAUSE_DONE  = 2'b10;
    localparam logic [1:0] CAUSE_BP    = 2'b11;

    state_e             state_q;
    logic [CNT_W-1:0]   remaining_q;
    logic               resume_q;
    logic [1:0]         cause_q;
    logic [31:0]        cycle_q;

    logic               bp_block;
    logic               accept;
    logic               halt_cmd;

    // resume_q masks the breakpoint for the first executed instruction after
    // a resume, so execution can leave a breakpoint PC.
    assign bp_block = bpEnable && (pc == bpAddr) && !resume_q && (state_q != S_STEP);
    assign cpuEn    = (state_q != S_HALT) && !bp_block;
    assign cmdReady = (state_q != S_STEP);
    assign accept   = cmdValid && cmdReady;
    assign halt_cmd = accept && (cmd == CMD_HALT);

    assign halted     = (state_q == S_HALT);
    assign haltCause  = cause_q;
    assign cycleCount = cycle_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN_ON_RESET ? S_RUN : S_HALT;
            remaining_q <= '0;
            resume_q    <= 1'b0;
            cause_q     <= CAUSE_RESET;
            cycle_q     <= '0;
        end else begin
            if (cpuEn) begin
                cycle_q  <= cycle_q + 32'd1;
                resume_q <= 1'b0;
            end

            case (state_q)
                S_HALT: begin
                    if (accept) begin
                        case (cmd)
                            CMD_RUN: begin
                                state_q  <= S_RUN;
                                resume_q <= 1'b1;
                            end
                            CMD_STEP: begin
                                state_q  <= S_STEP;
                                resume_q <= 1'b1;
                            end
                            CMD_RUNN: begin
                                resume_q <= 1'b1;
                                if (cmdCount != '0) begin
                                    state_q     <= S_RUNN;
                                    remaining_q <= cmdCount;
                                end else begin
                                    cause_q <= CAUSE_DONE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                S_STEP: begin
                    state_q <= S_HALT;
                    cause_q <= CAUSE_DONE;
                end

                S_RUN: begin
                    if (bp_block) begin
                        state_q <= S_HALT;
                        cause_q <= CAUSE_BP;
                    end else if (halt_cmd) begin
                        state_q <= S_HALT;
                        cause_q <= CAUSE_USER;
                    end
                end

                S_RUNN: begin
                    // Priority: breakpoint, then count-done, then user HALT.
                    if (bp_block) begin
                        state_q     <= S_HALT;
                        cause_q     <= CAUSE_BP;
                        remaining_q <= '0;
                    end else if (remaining_q == CNT_W'(1)) begin
                        state_q     <= S_HALT;
                        cause_q     <= CAUSE_DONE;
                        remaining_q <= '0;
                    end else if (halt_cmd) begin
                        state_q     <= S_HALT;
                        cause_q     <= CAUSE_USER;
                        remaining_q <= '0;
                    end else begin
                        remaining_q <= remaining_q - CNT_W'(1);
                    end
                end

                default: ;
            endcase
        end
    end

endmodule
